// File: rtl/montexp_pkg.sv
// Shared types and default sizes for the Montgomery modular-exponentiation sequencer.
package montexp_pkg;

  localparam int DEF_DATA_W = 512;
  localparam int DEF_EXP_W  = 512;
  localparam int DEF_LEN_W  = 10;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SQ_START,
    SQ_WAIT,
    MUL_START,
    MUL_WAIT,
    NEXT,
    POST_START,
    POST_WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ACC,
    OP_BASE,
    OP_ONE
  } opsel_e;

  function automatic logic is_start_state(input state_e s);
    return (s == SQ_START) || (s == MUL_START) || (s == POST_START);
  endfunction

endpackage

// File: rtl/montexp_operand_mux.sv
// Registered operand selection for the shared Montgomery multiplier.
module montexp_operand_mux
  import montexp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_i,
  input  opsel_e            sel_a_i,
  input  opsel_e            sel_b_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] base_i,
  output logic [DATA_W-1:0] mm_a_o,
  output logic [DATA_W-1:0] mm_b_o
);

  logic [DATA_W-1:0] a_d, a_q;
  logic [DATA_W-1:0] b_d, b_q;

  function automatic logic [DATA_W-1:0] pick(input opsel_e sel,
                                             input logic [DATA_W-1:0] acc,
                                             input logic [DATA_W-1:0] base);
    case (sel)
      OP_BASE: return base;
      OP_ONE:  return DATA_W'(1);
      default: return acc;
    endcase
  endfunction

  // Operands only change on entry to a START state and hold through the wait.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_i) begin
      a_d = pick(sel_a_i, acc_i, base_i);
      b_d = pick(sel_b_i, acc_i, base_i);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign mm_a_o = a_q;
  assign mm_b_o = b_q;

endmodule

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier,
// finishing with a multiply-by-one to leave the Montgomery domain.
module montgomery_exp_ctrl
  import montexp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_m,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [LEN_W-1:0]  in_e_len,
  output logic              mm_start,
  output logic [DATA_W-1:0] mm_a,
  output logic [DATA_W-1:0] mm_b,
  output logic [DATA_W-1:0] mm_m,
  input  logic [DATA_W-1:0] mm_result,
  input  logic              mm_done,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(EXP_W);

  state_e            state_d, state_q;
  logic [DATA_W-1:0] acc_d, acc_q;
  logic [DATA_W-1:0] base_d, base_q;
  logic [DATA_W-1:0] mod_d, mod_q;
  logic [EXP_W-1:0]  exp_d, exp_q;
  logic [LEN_W-1:0]  idx_d, idx_q;
  logic [DATA_W-1:0] result_d, result_q;
  logic [LEN_W-1:0]  start_len;
  logic              exp_bit;
  logic              load_ops;
  opsel_e            sel_a, sel_b;

  assign start_len = (in_e_len > MAX_LEN) ? MAX_LEN : in_e_len;
  assign exp_bit   = exp_q[idx_q[IDX_W-1:0]];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    mod_d    = mod_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = in_x;
          mod_d   = in_m;
          exp_d   = in_e;
          acc_d   = in_r;
          idx_d   = start_len;
          state_d = LOAD;
        end
      end
      LOAD, NEXT: begin
        if (idx_q == '0) begin
          state_d = POST_START;
        end else begin
          idx_d   = idx_q - LEN_W'(1);
          state_d = SQ_START;
        end
      end
      SQ_START:   state_d = SQ_WAIT;
      // mm_done is only honoured here, so a level left over from the prior transaction is never consumed.
      SQ_WAIT: begin
        if (mm_done) begin
          acc_d   = mm_result;
          state_d = exp_bit ? MUL_START : NEXT;
        end
      end
      MUL_START:  state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mm_done) begin
          acc_d   = mm_result;
          state_d = NEXT;
        end
      end
      POST_START: state_d = POST_WAIT;
      POST_WAIT: begin
        if (mm_done) begin
          result_d = mm_result;
          state_d  = DONE;
        end
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // The multiply after a square must see the freshly captured product, hence acc_d.
  always_comb begin
    load_ops = is_start_state(state_d);
    sel_a    = OP_ACC;
    sel_b    = OP_ACC;
    if (state_d == MUL_START) begin
      sel_b = OP_BASE;
    end else if (state_d == POST_START) begin
      sel_b = OP_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      mod_q    <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      mod_q    <= mod_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  montexp_operand_mux #(
    .DATA_W (DATA_W)
  ) u_operand_mux (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (load_ops),
    .sel_a_i (sel_a),
    .sel_b_i (sel_b),
    .acc_i   (acc_d),
    .base_i  (base_q),
    .mm_a_o  (mm_a),
    .mm_b_o  (mm_b)
  );

  assign mm_start = is_start_state(state_q);
  assign mm_m     = mod_q;
  assign result   = result_q;
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);

endmodule
